// File: rtl/dafx_pkg.sv
// dafx_pkg: shared widths, mixer defaults and the mixer state type for the DAFX datapath.
package dafx_pkg;

    localparam int AUDIO_WIDTH_C    = 24;
    localparam int GAIN_WIDTH_C     = 24;
    localparam int NR_OF_CHANNELS_C = 3;
    localparam int MIXER_CHANNELS_C = NR_OF_CHANNELS_C;
    localparam int MIXER_Q_BITS_C   = 11;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        MASTER,
        OUT
    } mixer_state_t;

endpackage

// File: rtl/dafx_saturate.sv
// dafx_saturate: narrows a signed value to OUT_WIDTH_P bits, clipping to the signed range
// and flagging when clipping occurred.
module dafx_saturate
    import dafx_pkg::*;
#(
    parameter int IN_WIDTH_P  = 2 * AUDIO_WIDTH_C,
    parameter int OUT_WIDTH_P = AUDIO_WIDTH_C
) (
    input  logic [IN_WIDTH_P-1:0]  d,
    output logic [OUT_WIDTH_P-1:0] q,
    output logic                   clip
);

    // All bits from the output sign position upward must agree, otherwise the value is out of range.
    logic [IN_WIDTH_P-OUT_WIDTH_P:0] hi;

    always_comb begin
        hi   = d[IN_WIDTH_P-1:OUT_WIDTH_P-1];
        clip = ~((&hi) | ~(|hi));
        q    = !clip ? d[OUT_WIDTH_P-1:0] :
               d[IN_WIDTH_P-1] ? {1'b1, {(OUT_WIDTH_P-1){1'b0}}} : {1'b0, {(OUT_WIDTH_P-1){1'b1}}};
    end

endmodule

// File: rtl/dafx_audio_mixer.sv
// dafx_audio_mixer: N-channel time-multiplexed gain/MAC mixer with master gain and saturation.
// Define DAFX_MIXER_CLIP_COUNT_EN to add a saturating clip-event counter.
module dafx_audio_mixer
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P    = AUDIO_WIDTH_C,
    parameter int GAIN_WIDTH_P     = GAIN_WIDTH_C,
    parameter int Q_BITS_P         = MIXER_Q_BITS_C,
    parameter int NR_OF_CHANNELS_P = MIXER_CHANNELS_C
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] x_channel_data,
    input  logic                                    x_channel_valid,
    output logic                                    x_channel_ready,
    input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  cr_mix_gain,
    input  logic [GAIN_WIDTH_P-1:0]                 cr_master_gain,
    output logic [AUDIO_WIDTH_P-1:0]                y_mix_data,
    output logic                                    y_mix_valid,
    input  logic                                    y_mix_ready,
`ifdef DAFX_MIXER_CLIP_COUNT_EN
    input  logic                                    cmd_clip_count_clear,
    output logic [31:0]                             sr_clip_count,
`endif
    output logic                                    sr_mix_clip
);

    localparam int A     = AUDIO_WIDTH_P;
    localparam int G     = GAIN_WIDTH_P;
    localparam int N     = NR_OF_CHANNELS_P;
    localparam int PW    = A + G;
    localparam int ACC_W = PW + $clog2(N) + 1;
    localparam int MW    = ACC_W + G;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    mixer_state_t             state_q, state_d;
    logic [N*A-1:0]           data_q;
    logic [N*G-1:0]           gain_q;
    logic [G-1:0]             master_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IW-1:0]            idx_q;
    logic [A-1:0]             s_cur;
    logic [G-1:0]             g_cur;
    logic signed [PW-1:0]     prod, prod_sh;
    logic signed [MW-1:0]     mprod, mscaled;
    logic [A-1:0]             sat;
    logic                     clip;

    always_comb begin
        s_cur   = data_q[idx_q*A +: A];
        g_cur   = gain_q[idx_q*G +: G];
        prod    = $signed({{G{s_cur[A-1]}}, s_cur}) * $signed({{A{g_cur[G-1]}}, g_cur});
        prod_sh = prod >>> Q_BITS_P;
        acc_d   = acc_q + $signed({{(ACC_W-PW){prod_sh[PW-1]}}, prod_sh});
        mprod   = $signed({{G{acc_q[ACC_W-1]}}, acc_q}) * $signed({{ACC_W{master_q[G-1]}}, master_q});
        mscaled = mprod >>> Q_BITS_P;
    end

    dafx_saturate #(
        .IN_WIDTH_P (MW),
        .OUT_WIDTH_P(A)
    ) u_sat (
        .d   (mscaled),
        .q   (sat),
        .clip(clip)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = x_channel_valid ? MAC : IDLE;
            MAC:     state_d = (idx_q == IW'(N - 1)) ? MASTER : MAC;
            MASTER:  state_d = OUT;
            OUT:     state_d = y_mix_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    assign x_channel_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            gain_q      <= '0;
            master_q    <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            y_mix_data  <= '0;
            y_mix_valid <= 1'b0;
            sr_mix_clip <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_mix_clip <= 1'b0;
            case (state_q)
                IDLE: if (x_channel_valid) begin
                    data_q   <= x_channel_data;
                    gain_q   <= cr_mix_gain;
                    master_q <= cr_master_gain;
                    acc_q    <= '0;
                    idx_q    <= '0;
                end
                MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IW'(1);
                end
                MASTER: begin
                    y_mix_data  <= sat;
                    y_mix_valid <= 1'b1;
                    sr_mix_clip <= clip;
                end
                OUT: if (y_mix_ready) y_mix_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef DAFX_MIXER_CLIP_COUNT_EN
    logic [31:0] clip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip_cnt <= '0;
        else if (cmd_clip_count_clear)
            clip_cnt <= '0;
        else if (sr_mix_clip && clip_cnt != '1)
            clip_cnt <= clip_cnt + 32'd1;
    end

    assign sr_clip_count = clip_cnt;
`endif

endmodule
